// File: rtl/ptw_mon_pkg.sv
// Shared types and constants for the PTW transaction monitor.
package ptw_mon_pkg;

  typedef enum logic [1:0] {
    EvtHit     = 2'd0,
    EvtMiss    = 2'd1,
    EvtAe      = 2'd2,
    EvtTimeout = 2'd3
  } evt_kind_e;

  // Channel walk state
  typedef logic [0:0] chan_state_t;
  localparam chan_state_t StIdle = 1'b0;
  localparam chan_state_t StWait = 1'b1;

  // PTE permission bit positions: {d,a,g,u,x,w,r,v}
  localparam int unsigned PermV = 0;
  localparam int unsigned PermR = 1;
  localparam int unsigned PermW = 2;
  localparam int unsigned PermX = 3;
  localparam int unsigned PermU = 4;
  localparam int unsigned PermG = 5;
  localparam int unsigned PermA = 6;
  localparam int unsigned PermD = 7;

  // Fixed-width part of an event record; width-parametric fields travel alongside it.
  typedef struct packed {
    evt_kind_e  kind;
    logic [7:0] perm;
  } evt_hdr_t;

endpackage

// File: rtl/ptw_chan_tracker.sv
// One PTW requestor channel: walk FSM, latency timer, classification and 1-deep pending slot.
module ptw_chan_tracker
  import ptw_mon_pkg::*;
#(
  parameter int unsigned VPN_W   = 27,
  parameter int unsigned PPN_W   = 44,
  parameter int unsigned LAT_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_en,
  input  logic             fire,
  input  logic [VPN_W-1:0] vpn,
  input  logic             resp_valid,
  input  logic             resp_ae,
  input  logic [PPN_W-1:0] resp_ppn,
  input  logic [7:0]       resp_perm,
  input  logic             slot_pop,
  output logic             slot_full,
  output evt_hdr_t         slot_hdr,
  output logic [VPN_W-1:0] slot_vpn,
  output logic [PPN_W-1:0] slot_ppn,
  output logic [LAT_W-1:0] slot_lat,
  output logic             new_evt,
  output evt_kind_e        new_kind,
  output logic [LAT_W-1:0] new_lat,
  output logic             new_drop,
  output logic             perr
);

  chan_state_t      state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d, lat_inc;
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic             in_wait, tmo, start;
  logic [PPN_W-1:0] new_ppn;
  logic [7:0]       new_perm;

  logic             slot_full_q, slot_full_d;
  evt_hdr_t         slot_hdr_q, slot_hdr_d;
  logic [VPN_W-1:0] slot_vpn_q, slot_vpn_d;
  logic [PPN_W-1:0] slot_ppn_q, slot_ppn_d;
  logic [LAT_W-1:0] slot_lat_q, slot_lat_d;

  // Walk completion detection and classification.
  always_comb begin
    in_wait = (state_q == StWait);
    lat_inc = (&lat_q) ? lat_q : lat_q + 1'b1;
    tmo     = in_wait && !resp_valid && (lat_q == LAT_W'(TIMEOUT - 1));
    new_evt = (in_wait && resp_valid) || tmo;
    if (tmo)                         new_kind = EvtTimeout;
    else if (resp_ae)                new_kind = EvtAe;
    else if (!resp_perm[PermV])      new_kind = EvtMiss;
    else                             new_kind = EvtHit;
    new_lat  = lat_inc;
    new_ppn  = (new_kind == EvtHit) ? resp_ppn : '0;
    new_perm = (new_kind == EvtHit || new_kind == EvtMiss) ? resp_perm : '0;
    perr     = (!in_wait && resp_valid) || (in_wait && fire && !resp_valid);
    // A completing walk may hand over to a new one in the same cycle.
    start    = fire && mon_en && (!in_wait || resp_valid);
  end

  // Next-state for the walk FSM and latency counter.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    vpn_d   = vpn_q;
    if (start) begin
      state_d = StWait;
      lat_d   = '0;
      vpn_d   = vpn;
    end else if (new_evt) begin
      state_d = StIdle;
    end else if (in_wait) begin
      lat_d = lat_inc;
    end
  end

  // Pending slot: refill allowed on the cycle it drains, otherwise a new event is dropped.
  always_comb begin
    new_drop    = new_evt && slot_full_q && !slot_pop;
    slot_full_d = slot_full_q && !slot_pop;
    slot_hdr_d  = slot_hdr_q;
    slot_vpn_d  = slot_vpn_q;
    slot_ppn_d  = slot_ppn_q;
    slot_lat_d  = slot_lat_q;
    if (new_evt && !new_drop) begin
      slot_full_d     = 1'b1;
      slot_hdr_d.kind = new_kind;
      slot_hdr_d.perm = new_perm;
      slot_vpn_d      = vpn_q;
      slot_ppn_d      = new_ppn;
      slot_lat_d      = new_lat;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      vpn_q       <= '0;
      slot_full_q <= 1'b0;
      slot_hdr_q  <= '0;
      slot_vpn_q  <= '0;
      slot_ppn_q  <= '0;
      slot_lat_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      vpn_q       <= vpn_d;
      slot_full_q <= slot_full_d;
      slot_hdr_q  <= slot_hdr_d;
      slot_vpn_q  <= slot_vpn_d;
      slot_ppn_q  <= slot_ppn_d;
      slot_lat_q  <= slot_lat_d;
    end
  end

  assign slot_full = slot_full_q;
  assign slot_hdr  = slot_hdr_q;
  assign slot_vpn  = slot_vpn_q;
  assign slot_ppn  = slot_ppn_q;
  assign slot_lat  = slot_lat_q;

endmodule

// File: rtl/ptw_multi_req_tracker.sv
// Observational PTW tracker: per-channel walk trackers, round-robin event stream, statistics.
module ptw_multi_req_tracker
  import ptw_mon_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned VPN_W   = 27,
  parameter int unsigned PPN_W   = 44,
  parameter int unsigned LAT_W   = 16,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mon_en,
  input  logic                     cnt_clr,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VPN_W-1:0] req_vpn,
  input  logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ae,
  input  logic [NUM_REQ*PPN_W-1:0] resp_ppn,
  input  logic [NUM_REQ*8-1:0]     resp_perm,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [IdW-1:0]           evt_id,
  output logic [1:0]               evt_kind,
  output logic [VPN_W-1:0]         evt_vpn,
  output logic [PPN_W-1:0]         evt_ppn,
  output logic [7:0]               evt_perm,
  output logic [LAT_W-1:0]         evt_lat,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic [CNT_W-1:0]         ae_cnt,
  output logic [CNT_W-1:0]         tmo_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         perr_cnt,
  output logic [LAT_W-1:0]         max_lat
);

  logic [NUM_REQ-1:0] fire, slot_full, slot_pop, new_evt, new_drop, perr;
  evt_hdr_t           slot_hdr [NUM_REQ];
  logic [VPN_W-1:0]   slot_vpn [NUM_REQ];
  logic [PPN_W-1:0]   slot_ppn [NUM_REQ];
  logic [LAT_W-1:0]   slot_lat [NUM_REQ];
  evt_kind_e          new_kind [NUM_REQ];
  logic [LAT_W-1:0]   new_lat  [NUM_REQ];

  assign fire = req_valid & req_ready;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_chan
    ptw_chan_tracker #(
      .VPN_W  (VPN_W),
      .PPN_W  (PPN_W),
      .LAT_W  (LAT_W),
      .TIMEOUT(TIMEOUT)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .mon_en    (mon_en),
      .fire      (fire[g]),
      .vpn       (req_vpn[g*VPN_W +: VPN_W]),
      .resp_valid(resp_valid[g]),
      .resp_ae   (resp_ae[g]),
      .resp_ppn  (resp_ppn[g*PPN_W +: PPN_W]),
      .resp_perm (resp_perm[g*8 +: 8]),
      .slot_pop  (slot_pop[g]),
      .slot_full (slot_full[g]),
      .slot_hdr  (slot_hdr[g]),
      .slot_vpn  (slot_vpn[g]),
      .slot_ppn  (slot_ppn[g]),
      .slot_lat  (slot_lat[g]),
      .new_evt   (new_evt[g]),
      .new_kind  (new_kind[g]),
      .new_lat   (new_lat[g]),
      .new_drop  (new_drop[g]),
      .perr      (perr[g])
    );
  end

  // ---------------- Output stage and arbiter ----------------
  logic             evt_valid_q;
  logic [IdW-1:0]   evt_id_q, id_next, ptr_q, start_idx, sel;
  evt_hdr_t         evt_hdr_q;
  logic [VPN_W-1:0] evt_vpn_q;
  logic [PPN_W-1:0] evt_ppn_q;
  logic [LAT_W-1:0] evt_lat_q;
  logic [NUM_REQ-1:0] busy, cand;
  logic             hs, load, found;
  int unsigned      arb_idx;

  // Round-robin pick among full slots; the slot currently presented is never re-picked.
  always_comb begin
    hs        = evt_valid_q && evt_ready;
    load      = !evt_valid_q || evt_ready;
    id_next   = (evt_id_q == IdW'(NUM_REQ - 1)) ? '0 : evt_id_q + 1'b1;
    start_idx = hs ? id_next : ptr_q;
    busy      = '0;
    slot_pop  = '0;
    if (evt_valid_q) busy[evt_id_q] = 1'b1;
    if (hs) slot_pop[evt_id_q] = 1'b1;
    cand    = slot_full & ~busy;
    found   = 1'b0;
    sel     = '0;
    arb_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_idx = (int'(start_idx) + k) % NUM_REQ;
      if (!found && cand[arb_idx]) begin
        found = 1'b1;
        sel   = IdW'(arb_idx);
      end
    end
  end

  // Event output register; contents held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      ptr_q       <= '0;
      evt_hdr_q   <= '0;
      evt_vpn_q   <= '0;
      evt_ppn_q   <= '0;
      evt_lat_q   <= '0;
    end else begin
      if (hs) ptr_q <= id_next;
      if (load) begin
        evt_valid_q <= found;
        if (found) begin
          evt_id_q  <= sel;
          evt_hdr_q <= slot_hdr[sel];
          evt_vpn_q <= slot_vpn[sel];
          evt_ppn_q <= slot_ppn[sel];
          evt_lat_q <= slot_lat[sel];
        end
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_kind  = evt_hdr_q.kind;
  assign evt_perm  = evt_hdr_q.perm;
  assign evt_vpn   = evt_vpn_q;
  assign evt_ppn   = evt_ppn_q;
  assign evt_lat   = evt_lat_q;

  // ---------------- Statistics ----------------
  logic [3:0]       hit_inc, miss_inc, ae_inc, tmo_inc, drop_inc, perr_inc;
  logic [LAT_W-1:0] lat_peak;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W - 3){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Per-cycle popcount of event classes across channels and running latency peak.
  always_comb begin
    hit_inc  = '0;
    miss_inc = '0;
    ae_inc   = '0;
    tmo_inc  = '0;
    drop_inc = '0;
    perr_inc = '0;
    lat_peak = max_lat;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      drop_inc = drop_inc + {3'b0, new_drop[i]};
      perr_inc = perr_inc + {3'b0, perr[i]};
      if (new_evt[i]) begin
        case (new_kind[i])
          EvtHit:     hit_inc  = hit_inc + 4'd1;
          EvtMiss:    miss_inc = miss_inc + 4'd1;
          EvtAe:      ae_inc   = ae_inc + 4'd1;
          EvtTimeout: tmo_inc  = tmo_inc + 4'd1;
          default:    ;
        endcase
        if (new_lat[i] > lat_peak) lat_peak = new_lat[i];
      end
    end
  end

  // Saturating counters; clear takes priority over same-cycle increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      ae_cnt   <= '0;
      tmo_cnt  <= '0;
      drop_cnt <= '0;
      perr_cnt <= '0;
      max_lat  <= '0;
    end else if (cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      ae_cnt   <= '0;
      tmo_cnt  <= '0;
      drop_cnt <= '0;
      perr_cnt <= '0;
      max_lat  <= '0;
    end else begin
      hit_cnt  <= sat_add(hit_cnt, hit_inc);
      miss_cnt <= sat_add(miss_cnt, miss_inc);
      ae_cnt   <= sat_add(ae_cnt, ae_inc);
      tmo_cnt  <= sat_add(tmo_cnt, tmo_inc);
      drop_cnt <= sat_add(drop_cnt, drop_inc);
      perr_cnt <= sat_add(perr_cnt, perr_inc);
      max_lat  <= lat_peak;
    end
  end

endmodule

// File: tb/tb_ptw_multi_req_tracker.sv
// Directed self-checking bench for ptw_multi_req_tracker (2 channels, TIMEOUT=16).
module tb_ptw_multi_req_tracker;

  localparam int unsigned NR = 2;
  localparam int unsigned VW = 27;
  localparam int unsigned PW = 44;
  localparam int unsigned LW = 16;
  localparam int unsigned CW = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mon_en = 1'b1;
  logic           cnt_clr = 1'b0;
  logic [NR-1:0]  req_valid = '0, req_ready = '0, resp_valid = '0, resp_ae = '0;
  logic [NR*VW-1:0] req_vpn = '0;
  logic [NR*PW-1:0] resp_ppn = '0;
  logic [NR*8-1:0]  resp_perm = '0;
  logic           evt_valid, evt_ready = 1'b0;
  logic [0:0]     evt_id;
  logic [1:0]     evt_kind;
  logic [VW-1:0]  evt_vpn;
  logic [PW-1:0]  evt_ppn;
  logic [7:0]     evt_perm;
  logic [LW-1:0]  evt_lat, max_lat;
  logic [CW-1:0]  hit_cnt, miss_cnt, ae_cnt, tmo_cnt, drop_cnt, perr_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ptw_multi_req_tracker #(
    .NUM_REQ(NR), .VPN_W(VW), .PPN_W(PW), .LAT_W(LW), .CNT_W(CW), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mon_en(mon_en), .cnt_clr(cnt_clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
    .resp_valid(resp_valid), .resp_ae(resp_ae), .resp_ppn(resp_ppn), .resp_perm(resp_perm),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id), .evt_kind(evt_kind),
    .evt_vpn(evt_vpn), .evt_ppn(evt_ppn), .evt_perm(evt_perm), .evt_lat(evt_lat),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .ae_cnt(ae_cnt), .tmo_cnt(tmo_cnt),
    .drop_cnt(drop_cnt), .perr_cnt(perr_cnt), .max_lat(max_lat)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [VW-1:0] v);
    req_valid[ch] = 1'b1;
    req_ready[ch] = 1'b1;
    req_vpn[ch*VW +: VW] = v;
  endtask

  task automatic set_resp(input int ch, input logic ae, input logic [PW-1:0] p, input logic [7:0] pm);
    resp_valid[ch] = 1'b1;
    resp_ae[ch] = ae;
    resp_ppn[ch*PW +: PW] = p;
    resp_perm[ch*8 +: 8] = pm;
  endtask

  task automatic clr_in();
    req_valid = '0;
    req_ready = '0;
    resp_valid = '0;
    resp_ae = '0;
  endtask

  // Check the presented record, then accept it with a one-cycle ready pulse.
  task automatic expect_evt(input string tag, input int id, input int kind,
                            input logic [VW-1:0] v, input logic [PW-1:0] p,
                            input logic [7:0] pm, input int lat);
    chk({tag, ".valid"}, 64'(evt_valid), 64'd1);
    chk({tag, ".id"},    64'(evt_id),    64'(id));
    chk({tag, ".kind"},  64'(evt_kind),  64'(kind));
    chk({tag, ".vpn"},   64'(evt_vpn),   64'(v));
    chk({tag, ".ppn"},   64'(evt_ppn),   64'(p));
    chk({tag, ".perm"},  64'(evt_perm),  64'(pm));
    chk({tag, ".lat"},   64'(evt_lat),   64'(lat));
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst.valid", 64'(evt_valid), 64'd0);
    chk("rst.hit",   64'(hit_cnt),   64'd0);
    chk("rst.maxlat", 64'(max_lat),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ch0 HIT with latency 5
    set_req(0, 27'h1234); tick(); clr_in();
    repeat (4) tick();
    set_resp(0, 1'b0, 44'hABCDE, 8'h0F); tick(); clr_in();
    chk("t1.hit_cnt", 64'(hit_cnt), 64'd1);
    tick();
    expect_evt("t1", 0, 0, 27'h1234, 44'hABCDE, 8'h0F, 5);
    chk("t1.drained", 64'(evt_valid), 64'd0);

    // ch1 MISS latency 3, then ch0 AE latency 1
    set_req(1, 27'h222); tick(); clr_in();
    repeat (2) tick();
    set_resp(1, 1'b0, 44'h55, 8'h0E); tick(); clr_in();
    tick();
    expect_evt("t2m", 1, 1, 27'h222, 44'h0, 8'h0E, 3);
    chk("t2.miss_cnt", 64'(miss_cnt), 64'd1);
    set_req(0, 27'h333); tick(); clr_in();
    set_resp(0, 1'b1, 44'h77, 8'hFF); tick(); clr_in();
    tick();
    expect_evt("t2a", 0, 2, 27'h333, 44'h0, 8'h00, 1);
    chk("t2.ae_cnt", 64'(ae_cnt), 64'd1);

    // ch0 timeout after 16 cycles, then a late response
    set_req(0, 27'h444); tick(); clr_in();
    repeat (15) tick();
    chk("t3.tmo_early", 64'(tmo_cnt), 64'd0);
    tick();
    chk("t3.tmo_cnt", 64'(tmo_cnt), 64'd1);
    tick();
    expect_evt("t3", 0, 3, 27'h444, 44'h0, 8'h00, 16);
    set_resp(0, 1'b0, 44'h9, 8'h01); tick(); clr_in();
    tick();
    chk("t3.perr_cnt", 64'(perr_cnt), 64'd1);
    chk("t3.no_evt", 64'(evt_valid), 64'd0);
    chk("t3.max_lat", 64'(max_lat), 64'd16);

    // ch1 HIT so the round-robin pointer returns to ch0
    set_req(1, 27'h555); tick(); clr_in();
    set_resp(1, 1'b0, 44'h999, 8'hC3); tick(); clr_in();
    tick();
    expect_evt("t4p", 1, 0, 27'h555, 44'h999, 8'hC3, 1);

    // Both channels complete in the same cycle: ch0 then ch1 back to back
    evt_ready = 1'b1;
    set_req(0, 27'h10); set_req(1, 27'h11); tick(); clr_in();
    set_resp(0, 1'b0, 44'h100, 8'h01); set_resp(1, 1'b0, 44'h101, 8'h01); tick(); clr_in();
    chk("t4.hit_cnt", 64'(hit_cnt), 64'd4);
    tick();
    chk("t4.first.valid", 64'(evt_valid), 64'd1);
    chk("t4.first.id", 64'(evt_id), 64'd0);
    chk("t4.first.vpn", 64'(evt_vpn), 64'h10);
    tick();
    chk("t4.second.valid", 64'(evt_valid), 64'd1);
    chk("t4.second.id", 64'(evt_id), 64'd1);
    chk("t4.second.ppn", 64'(evt_ppn), 64'h101);
    tick();
    chk("t4.drained", 64'(evt_valid), 64'd0);
    evt_ready = 1'b0;

    // Stalled consumer: second ch0 walk dropped, first record held
    set_req(0, 27'h600); tick(); clr_in();
    set_resp(0, 1'b0, 44'h1, 8'h01); tick(); clr_in();
    tick();
    set_req(0, 27'h601); tick(); clr_in();
    set_resp(0, 1'b0, 44'h2, 8'h01); tick(); clr_in();
    chk("t5.drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t5.hit_cnt", 64'(hit_cnt), 64'd6);
    chk("t5.held.valid", 64'(evt_valid), 64'd1);
    chk("t5.held.vpn", 64'(evt_vpn), 64'h600);
    chk("t5.held.ppn", 64'(evt_ppn), 64'h1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("t5.drained", 64'(evt_valid), 64'd0);

    // Monitoring disabled: fire ignored, response becomes a protocol error
    mon_en = 1'b0;
    set_req(1, 27'h700); tick(); clr_in();
    set_resp(1, 1'b0, 44'h0, 8'h01); tick(); clr_in();
    tick();
    mon_en = 1'b1;
    chk("t6.no_evt", 64'(evt_valid), 64'd0);
    chk("t6.perr_cnt", 64'(perr_cnt), 64'd2);
    chk("t6.hit_cnt", 64'(hit_cnt), 64'd6);

    // Clear coinciding with a completing walk
    set_req(1, 27'h800); tick(); clr_in();
    set_resp(1, 1'b0, 44'h3, 8'h01); cnt_clr = 1'b1; tick(); clr_in(); cnt_clr = 1'b0;
    chk("t7.hit_cnt", 64'(hit_cnt), 64'd0);
    chk("t7.perr_cnt", 64'(perr_cnt), 64'd0);
    chk("t7.drop_cnt", 64'(drop_cnt), 64'd0);
    chk("t7.max_lat", 64'(max_lat), 64'd0);
    tick();
    expect_evt("t7", 1, 0, 27'h800, 44'h3, 8'h01, 1);

    // Reset in the middle of a walk discards it
    set_resp(1, 1'b0, 44'h0, 8'h01); tick(); clr_in();
    chk("t8.perr_pre", 64'(perr_cnt), 64'd1);
    set_req(0, 27'h900); tick(); clr_in();
    repeat (2) tick();
    rst_n = 1'b0;
    #2;
    chk("t8.rst.perr", 64'(perr_cnt), 64'd0);
    chk("t8.rst.valid", 64'(evt_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    set_resp(0, 1'b0, 44'h5, 8'h01); tick(); clr_in();
    repeat (2) tick();
    chk("t8.no_evt", 64'(evt_valid), 64'd0);
    chk("t8.perr_cnt", 64'(perr_cnt), 64'd1);
    chk("t8.hit_cnt", 64'(hit_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
